// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcode map, FSM states and
// the predicate that routes an opcode to the iterative multiply/divide unit.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MULU = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_DIVU = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_SLL  = 4'd10;
    localparam logic [3:0] OP_SRL  = 4'd11;
    localparam logic [3:0] OP_SRA  = 4'd12;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_mc_seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// counter, one hi/lo shift register pair and one adder/subtractor.
module seq_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 mode_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   next_val,
    output logic                 div_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] operand;
    logic             div_mode;

    logic [WIDTH+1:0] add_x;
    logic [WIDTH+1:0] add_y;
    logic             add_cin;
    logic [WIDTH+1:0] add_sum;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    // Divide computes {hi,lo[msb]} - divisor in WIDTH+2 bits so the top bit
    // is the borrow; multiply adds the multiplicand when lo[0] is set.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        if (div_mode) begin
            add_x   = {1'b0, hi, lo[WIDTH-1]};
            add_y   = ~{2'b00, operand};
            add_cin = 1'b1;
        end else begin
            add_x   = {2'b00, hi};
            add_y   = lo[0] ? {2'b00, operand} : '0;
            add_cin = 1'b0;
        end
        add_sum = add_x + add_y + {{(WIDTH+1){1'b0}}, add_cin};
    end

    always_comb begin
        hi_n = hi;
        lo_n = lo;
        if (div_mode) begin
            if (add_sum[WIDTH+1]) begin
                hi_n = add_x[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b0};
            end else begin
                hi_n = add_sum[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            hi_n = add_sum[WIDTH:1];
            lo_n = {add_sum[0], lo[WIDTH-1:1]};
        end
    end

    assign next_val = {hi_n, lo_n};
    assign last     = (cnt == CW'(1));
    assign div_zero = div_mode && (operand == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            operand  <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            cnt      <= CW'(WIDTH);
            hi       <= '0;
            lo       <= mode_div ? a : b;
            operand  <= mode_div ? b : a;
            div_mode <= mode_div;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            hi  <= hi_n;
            lo  <= lo_n;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multicycle ALU: single-cycle logic/arithmetic ops plus iterative MULU/DIVU
// behind a start/busy/done handshake; all outputs registered.
module alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 zero,
    output logic                 ovf
);

    import alu_pkg::*;

    localparam int unsigned SW = $clog2(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   sum_add;
    logic [WIDTH-1:0]   diff_sub;
    logic [SW-1:0]      shamt;
    logic [WIDTH-1:0]   sc_r;
    logic               sc_ovf;
    logic               md_load;
    logic               md_last;
    logic [2*WIDTH-1:0] md_val;
    logic               md_dbz;

    assign sum_add  = a + b;
    assign diff_sub = a - b;
    assign shamt    = b[SW-1:0];

    always_comb begin
        sc_r   = '0;
        sc_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                sc_r   = sum_add;
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_r   = diff_sub;
                sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR:  sc_r = a ^ b;
            OP_AND:  sc_r = a & b;
            OP_OR:   sc_r = a | b;
            OP_NOR:  sc_r = ~(a | b);
            OP_SLT:  sc_r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: sc_r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  sc_r = a << shamt;
            OP_SRL:  sc_r = a >> shamt;
            OP_SRA:  sc_r = $signed(a) >>> shamt;
            default: sc_r = '0;
        endcase
    end

    assign md_load = (state == IDLE) && start && is_multicycle(op);

    seq_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .load     (md_load),
        .mode_div (op == OP_DIVU),
        .a        (a),
        .b        (b),
        .last     (md_last),
        .next_val (md_val),
        .div_zero (md_dbz)
    );

    // The final iteration's value is captured straight from the step logic so
    // completion lands on the same edge the counter reaches zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_multicycle(op)) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            result <= {{WIDTH{1'b0}}, sc_r};
                            zero   <= (sc_r == '0);
                            ovf    <= sc_ovf;
                            done   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (md_last) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= md_val;
                        zero   <= (md_val == '0);
                        ovf    <= md_dbz;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc at WIDTH=32 and WIDTH=8 against
// an arithmetic reference model.
module tb_alu_mc;

    localparam logic [3:0] T_ADD = 4'd0, T_MULU = 4'd2, T_XOR = 4'd3, T_SLT = 4'd6,
                           T_DIVU = 4'd8, T_SLTU = 4'd9, T_SRA = 4'd12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st32 = 1'b0, st8 = 1'b0;
    logic [3:0]  op32 = '0, op8 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy32, done32, zero32, ovf32;
    logic        busy8, done8, zero8, ovf8;
    logic [63:0] res32;
    logic [15:0] res8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(st32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(res32), .zero(zero32), .ovf(ovf32)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(st8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .zero(zero8), .ovf(ovf8)
    );

    task automatic check(input string tag, input longint unsigned got, input longint unsigned expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    endtask

    function automatic logic get_done(input bit w8); return w8 ? done8 : done32; endfunction
    function automatic logic get_busy(input bit w8); return w8 ? busy8 : busy32; endfunction
    function automatic logic get_zero(input bit w8); return w8 ? zero8 : zero32; endfunction
    function automatic logic get_ovf(input bit w8);  return w8 ? ovf8 : ovf32;   endfunction
    function automatic longint unsigned get_res(input bit w8);
        return w8 ? {48'd0, res8} : res32;
    endfunction

    // Reference: {ovf, result} from plain integer arithmetic on w-bit operands.
    function automatic logic [64:0] model(input logic [3:0] op, input longint unsigned a,
                                          input longint unsigned b, input int w);
        longint unsigned mask, r, wl;
        longint sa, sb, t, smax, smin;
        int sh;
        logic v;
        wl   = longint'(w);
        mask = (64'd1 << w) - 64'd1;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        sa   = (((a >> (w - 1)) & 64'd1) != 0) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb   = (((b >> (w - 1)) & 64'd1) != 0) ? longint'(b) - (longint'(1) << w) : longint'(b);
        sh   = int'(b % wl);
        v    = 1'b0;
        r    = 0;
        case (op)
            4'd0: begin t = sa + sb; r = longint'(t) & mask; v = (t > smax) || (t < smin); end
            4'd1: begin t = sa - sb; r = longint'(t) & mask; v = (t > smax) || (t < smin); end
            4'd2: r = a * b;
            4'd3: r = a ^ b;
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = (sa < sb) ? 64'd1 : 64'd0;
            4'd7: r = ~(a | b) & mask;
            4'd8: begin
                if (b == 0) begin r = (a << w) | mask; v = 1'b1; end
                else r = ((a % b) << w) | (a / b);
            end
            4'd9:  r = (a < b) ? 64'd1 : 64'd0;
            4'd10: r = (a << sh) & mask;
            4'd11: r = a >> sh;
            4'd12: begin t = sa >>> sh; r = longint'(t) & mask; end
            default: r = 0;
        endcase
        return {v, r};
    endfunction

    task automatic drive(input bit w8, input bit st, input logic [3:0] op,
                         input longint unsigned a, input longint unsigned b);
        if (w8) begin st8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
        else begin st32 = st; op32 = op; a32 = a[31:0]; b32 = b[31:0]; end
    endtask

    // Called just after the accept edge; scrambles inputs while busy.
    task automatic wait_done(input bit w8, output int cyc);
        cyc = 0;
        while (!get_done(w8) && cyc < 40) begin
            drive(w8, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
            @(posedge clk); #1;
            cyc++;
            check("done_busy_exclusive", get_done(w8) & get_busy(w8), 0);
        end
        check("done_seen", get_done(w8), 1);
    endtask

    task automatic do_op(input bit w8, input logic [3:0] op, input longint unsigned a_in,
                         input longint unsigned b_in, input string tag);
        int w, cyc;
        bit mc;
        longint unsigned a, b;
        logic [64:0] expv;
        w    = w8 ? 8 : 32;
        a    = a_in & ((64'd1 << w) - 64'd1);
        b    = b_in & ((64'd1 << w) - 64'd1);
        expv = model(op, a, b, w);
        mc   = (op == T_MULU) || (op == T_DIVU);
        drive(w8, 1'b1, op, a, b);
        @(posedge clk); #1;
        if (mc) check($sformatf("%s.busy", tag), get_busy(w8), 1);
        wait_done(w8, cyc);
        drive(w8, 1'b0, op, a, b);
        check($sformatf("%s.latency", tag), longint'(cyc), mc ? longint'(w) : 0);
        check($sformatf("%s.result", tag), get_res(w8), expv[63:0]);
        check($sformatf("%s.zero", tag), get_zero(w8), (expv[63:0] == 0) ? 1 : 0);
        check($sformatf("%s.ovf", tag), get_ovf(w8), expv[64]);
        @(posedge clk); #1;
        check($sformatf("%s.done_pulse", tag), get_done(w8), 0);
        check($sformatf("%s.idle", tag), get_busy(w8), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy32", busy32, 0);
        check("rst.done32", done32, 0);
        check("rst.res32", res32, 0);
        check("rst.zero32", zero32, 0);
        check("rst.ovf32", ovf32, 0);
        check("rst.res8", res8, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(0, T_ADD, 64'h7FFF_FFFF, 1, "add_ovf");
        check("add_ovf.const", res32, 64'h0000_0000_8000_0000);
        do_op(0, T_MULU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "mulu_max");
        check("mulu_max.const", res32, 64'hFFFF_FFFE_0000_0001);
        do_op(0, T_DIVU, 100, 7, "divu_100_7");
        check("divu_100_7.const", res32, {32'd2, 32'd14});
        do_op(0, T_DIVU, 5, 0, "divu_by0");
        check("divu_by0.const", res32, {32'd5, 32'hFFFF_FFFF});
        do_op(1, T_SLT, 8'h80, 8'h01, "slt8");
        check("slt8.const", res8, 1);
        do_op(1, T_SLTU, 8'h80, 8'h01, "sltu8");
        check("sltu8.const", res8, 0);
        do_op(1, T_SRA, 8'h80, 3, "sra8");
        check("sra8.const", res8, 16'h00F0);
        do_op(1, 4'd14, 8'h5A, 8'hA5, "rsvd8");
        check("rsvd8.zero_const", zero8, 1);

        // Abort a MULU mid-run; a start during busy must be ignored.
        do_op(0, T_ADD, 64'h7FFF_FFFF, 1, "pre_abort");
        drive(0, 1'b1, T_MULU, 3, 5);
        @(posedge clk); #1;
        drive(0, 1'b1, T_ADD, 1, 1);
        repeat (8) begin
            @(posedge clk); #1;
            check("ignore.busy", busy32, 1);
            check("ignore.done", done32, 0);
        end
        #2;
        reset = 1'b1;
        #1;
        check("abort.busy", busy32, 0);
        check("abort.done", done32, 0);
        check("abort.result", res32, 0);
        check("abort.zero", zero32, 0);
        check("abort.ovf", ovf32, 0);
        drive(0, 1'b0, T_ADD, 0, 0);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort.no_done", done32, 0);
        check("abort.idle", busy32, 0);
        do_op(0, T_MULU, 3, 5, "mulu_after_abort");
        check("mulu_after_abort.const", res32, 15);

        // Back-to-back: start XOR in the DIVU done cycle.
        drive(0, 1'b1, T_DIVU, 100, 7);
        @(posedge clk); #1;
        wait_done(0, cyc);
        check("b2b.div_result", res32, {32'd2, 32'd14});
        drive(0, 1'b1, T_XOR, 64'hF0F0_F0F0, 64'hFFFF_0000);
        @(posedge clk); #1;
        drive(0, 1'b0, T_XOR, 0, 0);
        check("b2b.xor_done", done32, 1);
        check("b2b.xor_busy", busy32, 0);
        check("b2b.xor_result", res32, 64'h0F0F_F0F0);
        @(posedge clk); #1;
        check("b2b.done_drop", done32, 0);

        for (int i = 0; i < 60; i++) begin
            longint unsigned ra, rb;
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 15));
            ra  = longint'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom);
            if ($urandom_range(0, 3) == 0) rb = rb & 64'hFF;
            do_op(1'(i % 2), rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
